// File: rtl/pwl_pkg.sv
// Shared widths, FSM encoding and the signed abs-difference helper for the
// PWL stream checker.
package pwl_pkg;

  localparam int DATA_W = 16;
  localparam int STAT_W = 17;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // 17-bit difference of two sign-extended samples; magnitude always fits unsigned 17 bits
  function automatic logic [STAT_W-1:0] abs_diff(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
    logic signed [STAT_W-1:0] d;
    d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    abs_diff = d[STAT_W-1] ? -d : d;
  endfunction

endpackage

// File: rtl/pwl_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; accepts a push while full when a
// pop happens in the same cycle.
module pwl_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_count = r_wptr - r_rptr;
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_empty = (o_count == '0);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/pwl_stream_checker.sv
// Drives an x sweep into two PWL activation units, aligns their result
// streams against the issued x values and accumulates mismatch statistics.
module pwl_stream_checker
  import pwl_pkg::*;
#(
  parameter int X_START       = -32768,
  parameter int X_END         = 32767,
  parameter int X_STEP        = 256,
  parameter int TOL           = 0,
  parameter int FIFO_DEPTH    = 8,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      x_valid,
  output logic signed [DATA_W-1:0]  x_out,
  input  logic                      a_valid,
  input  logic signed [DATA_W-1:0]  a_y,
  input  logic                      b_valid,
  input  logic signed [DATA_W-1:0]  b_y,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic                      overflow,
  output logic [STAT_W-1:0]         sample_cnt,
  output logic [STAT_W-1:0]         mismatch_cnt,
  output logic [STAT_W-1:0]         max_abs_diff,
  output logic signed [DATA_W-1:0]  max_diff_x
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic signed [STAT_W-1:0] X_START_S = STAT_W'(X_START);
  localparam logic signed [STAT_W-1:0] X_END_S   = STAT_W'(X_END);
  localparam logic signed [STAT_W-1:0] X_STEP_S  = STAT_W'(X_STEP);
  localparam logic [STAT_W-1:0]        TOL_U     = STAT_W'(TOL);
  localparam logic [TW-1:0]            TO_LAST   = TW'(DRAIN_TIMEOUT - 1);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]                r_state;
  logic signed [STAT_W-1:0]  r_x_next;
  logic [STAT_W-1:0]         r_issued;
  logic [TW-1:0]             r_idle;
  logic                      r_timeout;
  logic                      r_overflow;
  logic [STAT_W-1:0]         r_sample_cnt;
  logic [STAT_W-1:0]         r_mismatch_cnt;
  logic [STAT_W-1:0]         r_max_abs;
  logic signed [DATA_W-1:0]  r_max_x;
  logic                      r_vld_p1;
  logic [STAT_W-1:0]         r_abs_p1;
  logic signed [DATA_W-1:0]  r_x_p1;

  logic                      w_busy;
  logic                      w_clr;
  logic signed [STAT_W-1:0]  w_x_step;
  logic                      w_issue;
  logic                      w_a_push;
  logic                      w_b_push;
  logic                      w_pop;
  logic                      w_ovf;
  logic [STAT_W-1:0]         w_abs_p0;
  logic signed [DATA_W-1:0]  w_x_rd;
  logic signed [DATA_W-1:0]  w_a_rd;
  logic signed [DATA_W-1:0]  w_b_rd;
  logic                      w_x_full, w_x_empty;
  logic                      w_a_full, w_a_empty;
  logic                      w_b_full, w_b_empty;
  logic [CW-1:0]             w_x_count, w_a_count, w_b_count;
  logic                      w_unused;

  assign w_busy   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_clr    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_x_step = r_x_next + X_STEP_S;
  // x FIFO occupancy is exactly the number of issued-but-uncompared samples
  assign w_issue  = (r_state == ST_RUN) && (w_x_count < CW'(FIFO_DEPTH)) && (r_x_next <= X_END_S);
  assign w_a_push = a_valid && w_busy;
  assign w_b_push = b_valid && w_busy;
  assign w_pop    = w_busy && !w_x_empty && !w_a_empty && !w_b_empty;
  assign w_ovf    = (w_a_push && w_a_full && !w_pop) || (w_b_push && w_b_full && !w_pop);
  assign w_abs_p0 = abs_diff(w_a_rd, w_b_rd);
  assign w_unused = ^{w_x_full, w_a_count, w_b_count};

  pwl_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_x (
    .i_clk(clk), .i_rst(rst), .i_clr(w_clr), .i_push(w_issue), .i_pop(w_pop),
    .i_wdata(x_out), .o_rdata(w_x_rd), .o_full(w_x_full), .o_empty(w_x_empty),
    .o_count(w_x_count)
  );

  pwl_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .i_clk(clk), .i_rst(rst), .i_clr(w_clr), .i_push(w_a_push), .i_pop(w_pop),
    .i_wdata(a_y), .o_rdata(w_a_rd), .o_full(w_a_full), .o_empty(w_a_empty),
    .o_count(w_a_count)
  );

  pwl_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .i_clk(clk), .i_rst(rst), .i_clr(w_clr), .i_push(w_b_push), .i_pop(w_pop),
    .i_wdata(b_y), .o_rdata(w_b_rd), .o_full(w_b_full), .o_empty(w_b_empty),
    .o_count(w_b_count)
  );

  // p0 -> p1: register popped pair's magnitude and its x
  always_ff @(posedge clk) begin
    r_abs_p1 <= w_abs_p0;
    r_x_p1   <= w_x_rd;
    if (w_clr)        r_x_next <= X_START_S;
    else if (w_issue) r_x_next <= w_x_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_issued       <= '0;
      r_idle         <= '0;
      r_vld_p1       <= 1'b0;
      r_timeout      <= 1'b0;
      r_overflow     <= 1'b0;
      r_sample_cnt   <= '0;
      r_mismatch_cnt <= '0;
      r_max_abs      <= '0;
      r_max_x        <= '0;
    end else begin
      r_vld_p1 <= w_pop;
      if (w_ovf) r_overflow <= 1'b1;
      // p1: fold registered pair into statistics; a restart below overrides
      if (r_vld_p1) begin
        r_sample_cnt <= sat_inc(r_sample_cnt);
        if (r_abs_p1 > TOL_U) r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
        if (r_abs_p1 > r_max_abs) begin
          r_max_abs <= r_abs_p1;
          r_max_x   <= r_x_p1;
        end
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state        <= ST_RUN;
            r_issued       <= '0;
            r_idle         <= '0;
            r_timeout      <= 1'b0;
            r_overflow     <= 1'b0;
            r_sample_cnt   <= '0;
            r_mismatch_cnt <= '0;
            r_max_abs      <= '0;
            r_max_x        <= '0;
          end
        end
        ST_RUN: begin
          r_idle <= '0;
          if (w_issue) begin
            r_issued <= sat_inc(r_issued);
            if (w_x_step > X_END_S) r_state <= ST_DRAIN;
          end else if (r_x_next > X_END_S) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_sample_cnt == r_issued) begin
            r_state <= ST_DONE;
          end else if (w_pop || r_vld_p1) begin
            r_idle <= '0;
          end else if (r_idle == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign x_valid      = w_issue;
  assign x_out        = w_issue ? r_x_next[DATA_W-1:0] : '0;
  assign busy         = w_busy;
  assign done         = (r_state == ST_DONE);
  assign timeout      = r_timeout;
  assign overflow     = r_overflow;
  assign sample_cnt   = r_sample_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
  assign max_abs_diff = r_max_abs;
  assign max_diff_x   = r_max_x;

endmodule

// File: tb/tb_pwl_stream_checker.sv
// Directed bench: three checker instances (short sweep, shallow FIFO, extreme
// range) fed by behavioural delay-line DUT models.
module tb_pwl_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, clr_mon;
  logic               x_valid[3];
  logic signed [15:0] x_out[3];
  logic               a_valid[3], b_valid[3];
  logic signed [15:0] a_y[3], b_y[3];
  logic               busy[3], done[3], timeout[3], overflow[3];
  logic [16:0]        sample_cnt[3], mismatch_cnt[3], max_abs_diff[3];
  logic signed [15:0] max_diff_x[3];

  int lat_a[3], lat_b[3], mode[3];
  bit en_b[3];
  logic [7:0]         sr_v[3];
  logic signed [15:0] sr_x[3][8];

  int nvec = 0, nfail = 0;
  int xn, iss1, bres1, maxout1, gaps1;
  logic signed [15:0] xlog[16];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pwl_stream_checker #(
      .X_START(g == 2 ? 32000 : -8), .X_END(g == 2 ? 32767 : 8),
      .X_STEP(g == 2 ? 500 : 4), .TOL(0),
      .FIFO_DEPTH(g == 1 ? 2 : 8), .DRAIN_TIMEOUT(64)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .x_valid(x_valid[g]), .x_out(x_out[g]),
      .a_valid(a_valid[g]), .a_y(a_y[g]), .b_valid(b_valid[g]), .b_y(b_y[g]),
      .busy(busy[g]), .done(done[g]), .timeout(timeout[g]), .overflow(overflow[g]),
      .sample_cnt(sample_cnt[g]), .mismatch_cnt(mismatch_cnt[g]),
      .max_abs_diff(max_abs_diff[g]), .max_diff_x(max_diff_x[g])
    );
  end

  // Behavioural PWL units: fixed-latency delay lines with selectable output mapping
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      sr_v[k]    <= {sr_v[k][6:0], x_valid[k]};
      sr_x[k][0] <= x_out[k];
      for (int i = 1; i < 8; i++) sr_x[k][i] <= sr_x[k][i-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      logic signed [15:0] ax, bx;
      ax = sr_x[k][3'(lat_a[k]-1)];
      bx = sr_x[k][3'(lat_b[k]-1)];
      a_valid[k] = sr_v[k][3'(lat_a[k]-1)];
      b_valid[k] = en_b[k] && sr_v[k][3'(lat_b[k]-1)];
      a_y[k] = (mode[k] == 2) ? 16'sh7fff : ax;
      if (mode[k] == 2)                  b_y[k] = 16'sh8000;
      else if (mode[k] == 1 && bx == 0)  b_y[k] = 16'sd3;
      else                               b_y[k] = bx;
    end
  end

  always @(negedge clk) begin
    if (clr_mon) begin
      xn = 0; iss1 = 0; bres1 = 0; maxout1 = 0; gaps1 = 0;
    end else begin
      if (x_valid[0]) begin
        if (xn < 16) xlog[xn] = x_out[0];
        xn++;
      end
      if (busy[1] && !x_valid[1] && iss1 > 0 && iss1 < 5) gaps1++;
      if (x_valid[1]) iss1++;
      if (b_valid[1]) bres1++;
      if (iss1 - bres1 > maxout1) maxout1 = iss1 - bres1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(posedge clk); #1;
    clr_mon = 1'b0;
  endtask

  task automatic run_sweep(input int bound);
    int n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweep_done", {29'd0, done[0], done[1], done[2]}, 32'd7);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; clr_mon = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat_a[k] = 1; lat_b[k] = 1; mode[k] = 0; en_b[k] = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_xvalid", x_valid[0], 0);
    chk("rst_samples", sample_cnt[0], 0);
    chk("rst_maxdiff", max_abs_diff[0], 0);
    chk("rst_flags", {timeout[0], overflow[0]}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Short identity sweep on all instances
    clear_mon();
    run_sweep(300);
    chk("p1_issue_count", xn, 5);
    chk("p1_x0", xlog[0], -8);
    chk("p1_x1", xlog[1], -4);
    chk("p1_x2", xlog[2], 0);
    chk("p1_x3", xlog[3], 4);
    chk("p1_x4", xlog[4], 8);
    chk("p1_samples", sample_cnt[0], 5);
    chk("p1_mismatch", mismatch_cnt[0], 0);
    chk("p1_maxdiff", max_abs_diff[0], 0);
    chk("p1_timeout", timeout[0], 0);
    chk("p1_d1_samples", sample_cnt[1], 5);
    chk("p1_d2_samples", sample_cnt[2], 2);

    // Latency skew with one mismatch; extreme-range instance sees full-scale diff
    repeat (10) @(posedge clk);
    #1;
    lat_b[0] = 5; mode[0] = 1; mode[2] = 2;
    run_sweep(300);
    chk("skew_samples", sample_cnt[0], 5);
    chk("skew_mismatch", mismatch_cnt[0], 1);
    chk("skew_maxdiff", max_abs_diff[0], 3);
    chk("skew_maxx", max_diff_x[0], 0);
    chk("ext_samples", sample_cnt[2], 2);
    chk("ext_maxdiff", max_abs_diff[2], 65535);
    chk("ext_mismatch", mismatch_cnt[2], 2);
    chk("ext_maxx", max_diff_x[2], 32000);

    // Backpressure on the depth-2 instance
    repeat (10) @(posedge clk);
    #1;
    lat_b[0] = 1; mode[0] = 0; mode[2] = 0; lat_b[1] = 6;
    clear_mon();
    run_sweep(300);
    chk("bp_gaps_seen", (gaps1 > 0), 1);
    chk("bp_outstanding_le2", (maxout1 <= 2), 1);
    chk("bp_overflow", overflow[1], 0);
    chk("bp_samples", sample_cnt[1], 5);

    // B never answers on instance 0
    repeat (10) @(posedge clk);
    #1;
    lat_b[1] = 1; en_b[0] = 1'b0;
    run_sweep(400);
    chk("to_done", done[0], 1);
    chk("to_timeout", timeout[0], 1);
    chk("to_samples", sample_cnt[0], 0);
    chk("to_busy", busy[0], 0);

    // Reset in the middle of RUN, then a clean rerun
    repeat (10) @(posedge clk);
    #1;
    en_b[0] = 1'b1;
    clear_mon();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (xn < 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reached_3", (xn >= 3), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_xvalid", x_valid[0], 0);
    chk("mid_busy", busy[0], 0);
    chk("mid_done", done[0], 0);
    chk("mid_samples", sample_cnt[0], 0);
    chk("mid_mismatch", mismatch_cnt[0], 0);
    repeat (10) @(posedge clk);
    #1;
    clear_mon();
    run_sweep(300);
    chk("rerun_issue_count", xn, 5);
    chk("rerun_last_x", xlog[4], 8);
    chk("rerun_samples", sample_cnt[0], 5);
    chk("rerun_mismatch", mismatch_cnt[0], 0);
    chk("rerun_flags", {timeout[0], overflow[0]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/pwl_stream_checker.md
Name: pwl_stream_checker

Overview:
- Hardware stimulus/response counterpart of the PWL activation units (sigmoid/tanh, original and optimized).
- Drives one Q-format x sweep into two DUT instances (A = original, B = optimized) over the valid/x interface.
- Receives both valid/y result streams, aligns them in order, and accumulates mismatch statistics.
- Replaces file-based comparison for on-chip or self-checking regression.

Parameters:
- X_START, -32768, first x value issued (signed 16-bit).
- X_END, 32767, last allowed x value (inclusive, signed 16-bit).
- X_STEP, 256, increment between samples (1..32767).
- TOL, 0, max |yA-yB| not counted as mismatch.
- FIFO_DEPTH, 8, per-stream alignment buffer depth (power of 2, >=2).
- DRAIN_TIMEOUT, 64, idle cycles allowed in DRAIN before abort.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins sweep when IDLE or DONE, ignored otherwise.
- x_valid  out  1  x_out valid this cycle (to both DUT valid_in).
- x_out  out  16  signed sample to both DUTs.
- a_valid  in  1  DUT A result strobe.
- a_y  in  16  DUT A result, signed.
- b_valid  in  1  DUT B result strobe.
- b_y  in  16  DUT B result, signed.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE state.
- timeout  out  1  sticky: DRAIN ended by timeout.
- overflow  out  1  sticky: result pushed into a full FIFO.
- sample_cnt  out  17  number of compared pairs.
- mismatch_cnt  out  17  pairs with |diff| > TOL.
- max_abs_diff  out  17  largest |yA-yB| seen.
- max_diff_x  out  16  x of first pair reaching max_abs_diff.

Behaviour:
- Reset: state IDLE; all outputs 0; FIFOs empty; issued/compared counters 0.
- FSM states:
  - IDLE: on start, clear counters, stats and sticky flags; load x_next=X_START; go to RUN.
  - RUN: each cycle with outstanding (issued - compared) < FIFO_DEPTH, assert x_valid with x_out=x_next, push x_out into the x FIFO, and advance x_next by X_STEP.
    - Step and compare use a 17-bit signed sum, so no 16-bit wrap.
    - The last issue is the final x <= X_END; then go to DRAIN.
    - If outstanding reaches FIFO_DEPTH, hold x_valid low (stall); the DUTs tolerate gaps.
  - DRAIN: no issue. When compared == issued, go to DONE. If DRAIN_TIMEOUT consecutive cycles pass with no compare, set timeout and go to DONE.
  - DONE: outputs frozen; start restarts the sweep (same as from IDLE).
- Alignment: a_valid pushes a_y into FIFO A; b_valid pushes b_y into FIFO B.
  - Any push into a full FIFO sets overflow; that data is dropped.
  - A push on an unsolicited strobe (no outstanding x) is a push into the empty-to-x scheme: it is still stored, and it ends in timeout/mismatch.
- Compare: in any cycle where FIFO A, FIFO B and the x FIFO are all non-empty, pop all three (one pair per cycle).
  - diff = sext17(yA) - sext17(yB); abs is 17-bit unsigned.
  - sample_cnt += 1.
  - mismatch_cnt += 1 if abs > TOL.
  - If abs > max_abs_diff, update max_abs_diff and max_diff_x. Ties do not update.
- Statistics registers update one cycle after the pop (1-cycle compare pipeline). DRAIN completion counts that pipeline stage.
- Simultaneous push and pop on the same FIFO in one cycle is legal, including when full.
- Strobes arriving while IDLE or DONE are ignored (not pushed).
- rst mid-sweep: immediate return to IDLE, everything cleared, x_valid low next cycle.
- Counters saturate at all-ones.

Decomposition:
- Shared package pwl_pkg:
  - data width 16 and stat width 17 constants;
  - FSM state encoding (IDLE, RUN, DRAIN, DONE);
  - abs-diff helper function.
- Sub-module pwl_sync_fifo (parameterised width/depth; push, pop, full, empty, count) is instantiated three times: x, A, B.

Test Plan:
- Short sweep: X_START=-8, X_END=8, X_STEP=4, both DUTs identity with 1-cycle latency -> x_out = -8,-4,0,4,8; sample_cnt=5; mismatch_cnt=0; max_abs_diff=0; done high; timeout=0.
- Latency skew: A latency 1, B latency 5, same sweep, B = A+3 on x=0 only, TOL=0 -> mismatch_cnt=1, max_abs_diff=3, max_diff_x=0.
- Backpressure: FIFO_DEPTH=2, B latency 6 -> x_valid gaps observed; outstanding never >2; overflow=0; sample_cnt=5.
- Timeout: B never responds -> after DRAIN_TIMEOUT=64 idle cycles, done=1, timeout=1, sample_cnt=0.
- Extremes/wrap: X_START=32000, X_END=32767, X_STEP=500 -> issues 32000, 32500 only (no wrap); yA=32767, yB=-32768 -> max_abs_diff=65535.
- Reset mid-RUN at sample 3 -> next cycle x_valid=0, all stats 0, IDLE; a new start gives clean results.
